md_unit: RTL

Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core.
It sits beside the single-cycle ALU in the EX stage and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests.
Long operations run for multiple cycles. The unit raises busy so the hazard unit can stall, and it exposes HI/LO for MFHI/MFLO.

---
 rtl/md_unit_pkg.sv | 36 +++
 rtl/md_unit_if.sv | 19 +
 rtl/md_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared control encodings (ALU and multiply/divide op codes) plus md_unit decode helpers.
`ifndef CTRL_ENC_DEFS
`define CTRL_ENC_DEFS
`define ALUOp_ADD   4'd0
`define ALUOp_SUB   4'd1
`define ALUOp_AND   4'd2
`define ALUOp_OR    4'd3
`define ALUOp_XOR   4'd4
`define ALUOp_NOR   4'd5
`define ALUOp_SLT   4'd6
`define ALUOp_SLTU  4'd7
`define MDOp_MULT   3'd0
`define MDOp_MULTU  3'd1
`define MDOp_DIV    3'd2
`define MDOp_DIVU   3'd3
`define MDOp_MTHI   3'd4
`define MDOp_MTLO   3'd5
`define MDOp_NOP6   3'd6
`define MDOp_NOP7   3'd7
`endif

package md_unit_pkg;
  localparam int MD_WIDTH = 32;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == `MDOp_MULT) || (op == `MDOp_MULTU) || (op == `MDOp_DIV) || (op == `MDOp_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == `MDOp_MULT) || (op == `MDOp_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == `MDOp_DIV) || (op == `MDOp_DIVU);
  endfunction
endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and md_unit.
interface md_unit_if
  import md_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, md_op, A, B, cancel, input busy, done, hi, lo);
  modport slave  (input start, md_op, A, B, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Iterative multiply/divide with HI/LO: WIDTH iterations plus one sign-fix cycle, busy for WIDTH+1 cycles.
// One 2*WIDTH shift register and one WIDTH+1 adder serve both shift-add multiply and restoring divide.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic     clk,
  input  logic     rstn,
  md_unit_if.slave md
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   dvnd_q, dvnd_d;   // raw dividend, returned in hi on divide-by-zero
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_a, add_b;
  logic [WIDTH+1:0]   add_s;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    sgn_op = is_signed_op(md.md_op);
    a_neg  = sgn_op & md.A[WIDTH-1];
    b_neg  = sgn_op & md.B[WIDTH-1];
    a_mag  = a_neg ? -md.A : md.A;
    b_mag  = b_neg ? -md.B : md.B;

    // Divide subtracts via inverted operand + carry-in; the carry out is "remainder >= divisor".
    if (is_div_q) begin
      add_a = acc_q[2*WIDTH-1:WIDTH-1];
      add_b = ~{1'b0, opnd_q};
    end else begin
      add_a = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b = acc_q[0] ? {1'b0, opnd_q} : '0;
    end
    add_s  = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, is_div_q};
    div_ge = add_s[WIDTH+1];

    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    dvnd_d   = dvnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (md.start && !md.cancel) begin
          if (is_long_op(md.md_op)) begin
            is_div_d = is_div_op(md.md_op);
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = is_div_op(md.md_op) & a_neg;
            dz_d     = is_div_op(md.md_op) & (md.B == '0);
            dvnd_d   = md.A;
            if (is_div_op(md.md_op)) begin
              acc_d  = {{WIDTH{1'b0}}, a_mag};
              opnd_d = b_mag;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, b_mag};
              opnd_d = a_mag;
            end
            cnt_d   = '0;
            state_d = RUN;
          end else if (md.md_op == `MDOp_MTHI) begin
            hi_d = md.A;
          end else if (md.md_op == `MDOp_MTLO) begin
            lo_d = md.A;
          end
        end
      end
      RUN: begin
        if (md.cancel) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = div_ge ? {add_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                           : {acc_q[2*WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {add_s[WIDTH:0], acc_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
          else                       cnt_d   = cnt_q + 1'b1;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!md.cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (dz_q) begin
            hi_d = dvnd_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      dvnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      dvnd_q   <= dvnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign md.busy = (state_q != IDLE);
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
endmodule
